// File: rtl/sha3_pkg.sv
// SHA3-256 padder shared constants and state type.
package sha3_pkg;
   localparam int RATE_BYTES = 136;
   localparam int BEATS      = 8;
   localparam int BEAT_W     = 200;
   localparam int STATE_W    = 1600;

   localparam logic [7:0] DSBYTE_SHA3 = 8'h06;
   localparam logic [7:0] PAD_LAST    = 8'h80;

   typedef enum logic [1:0] {
      S_FILL,
      S_READY,
      S_EMIT,
      S_PADBLK
   } pad_state_t;
endpackage

// File: rtl/sha3_padder.sv
// SHA3-256 byte padder: fills a rate block, pads it and
// streams it to the permutation as eight 200-bit beats.
module sha3_padder
   import sha3_pkg::*;
#(
   parameter int         RATE_BYTES = sha3_pkg::RATE_BYTES,
   parameter logic [7:0] DSBYTE     = sha3_pkg::DSBYTE_SHA3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pushin,
   input  logic [7:0]        din,
   input  logic              endin,
   input  logic              permrdy,
   output logic              busy,
   output logic              pushout,
   output logic [2:0]        doutix,
   output logic [BEAT_W-1:0] dout,
   output logic              firstout,
   output logic              finalout
);

   localparam int RW   = RATE_BYTES * 8;
   localparam int LAST = (RATE_BYTES - 1) * 8;
   localparam logic [7:0] CNT_LAST = 8'(RATE_BYTES - 1);
   localparam logic [RW-1:0] PAD_BLK =
      (RW'(PAD_LAST) << LAST) | RW'(DSBYTE);

   pad_state_t r_state;
   pad_state_t w_next;

   logic [RW-1:0]      r_buf;
   logic [RW-1:0]      w_fill_buf;
   logic [7:0]         r_cnt;
   logic [7:0]         w_p;
   logic               r_padpend;
   logic               r_msgfirst;
   logic               r_final;
   logic               r_busy;
   logic               r_pushout;
   logic               r_firstout;
   logic               r_finalout;
   logic [2:0]         r_doutix;
   logic [BEAT_W-1:0]  r_dout;
   logic [2:0]         w_bix;
   logic [10:0]        w_off;
   logic [STATE_W-1:0] w_blk;
   logic [BEAT_W-1:0]  w_beat;
   logic               w_last_byte;
   logic               w_endpad;
   logic               w_beat_end;

   assign w_last_byte = pushin && (r_cnt == CNT_LAST);
   assign w_endpad    = endin && !w_last_byte;
   assign w_beat_end  = (r_doutix == 3'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_FILL: begin
            if (endin || w_last_byte) begin
               w_next = S_READY;
            end
         end
         S_READY: begin
            if (permrdy) begin
               w_next = S_EMIT;
            end
         end
         S_EMIT: begin
            if (w_beat_end) begin
               w_next = r_padpend ? S_PADBLK : S_FILL;
            end
         end
         S_PADBLK: begin
            w_next = S_READY;
         end
         default: begin
            w_next = S_FILL;
         end
      endcase
   end

   // Byte p gets the domain byte, the last rate byte gets 0x80;
   // XOR makes the p == last case collapse to 0x86.
   always_comb begin
      w_fill_buf = r_buf;
      w_p = r_cnt + {7'd0, pushin};
      if (pushin) begin
         w_fill_buf[{r_cnt, 3'b000} +: 8] = din;
      end
      if (w_endpad) begin
         w_fill_buf[{w_p, 3'b000} +: 8] =
            w_fill_buf[{w_p, 3'b000} +: 8] ^ DSBYTE;
         w_fill_buf[LAST +: 8] =
            w_fill_buf[LAST +: 8] ^ PAD_LAST;
      end
   end

   assign w_bix = (r_state == S_EMIT) ? r_doutix + 3'd1 : 3'd0;
   assign w_off = 11'(w_bix) * 11'(BEAT_W);
   assign w_blk = {{(STATE_W - RW){1'b0}}, r_buf};
   assign w_beat = w_blk[w_off +: BEAT_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf      <= '0;
         r_cnt      <= '0;
         r_padpend  <= 1'b0;
         r_msgfirst <= 1'b1;
         r_final    <= 1'b0;
         r_busy     <= 1'b0;
         r_pushout  <= 1'b0;
         r_firstout <= 1'b0;
         r_finalout <= 1'b0;
         r_doutix   <= '0;
         r_dout     <= '0;
      end else begin
         r_busy <= (w_next != S_FILL);
         unique case (r_state)
            S_FILL: begin
               r_buf <= w_fill_buf;
               if (pushin) begin
                  r_cnt <= r_cnt + 8'd1;
               end
               if (endin || w_last_byte) begin
                  r_final   <= w_endpad;
                  r_padpend <= endin && w_last_byte;
               end
            end
            S_READY: begin
               if (permrdy) begin
                  r_pushout  <= 1'b1;
                  r_doutix   <= '0;
                  r_dout     <= w_beat;
                  r_firstout <= r_msgfirst;
                  r_finalout <= r_final;
               end
            end
            S_EMIT: begin
               if (w_beat_end) begin
                  r_pushout  <= 1'b0;
                  r_doutix   <= '0;
                  r_dout     <= '0;
                  r_firstout <= 1'b0;
                  r_finalout <= 1'b0;
                  r_buf      <= '0;
                  r_cnt      <= '0;
                  r_msgfirst <= r_final;
               end else begin
                  r_doutix   <= r_doutix + 3'd1;
                  r_dout     <= w_beat;
                  r_firstout <= 1'b0;
               end
            end
            S_PADBLK: begin
               r_buf     <= PAD_BLK;
               r_final   <= 1'b1;
               r_padpend <= 1'b0;
            end
            default: begin
               r_buf <= r_buf;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign pushout  = r_pushout;
   assign doutix   = r_doutix;
   assign dout     = r_dout;
   assign firstout = r_firstout;
   assign finalout = r_finalout;

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder: table of expected bursts
// plus hand-written stall and reset-mid-burst sequences.
module tb_sha3_padder;
   import sha3_pkg::*;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      int           sc;
      int           b;
      logic [199:0] d[8];
      logic         f;
      logic         l;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         pushin;
   logic [7:0]   din;
   logic         endin;
   logic         permrdy;
   logic         busy;
   logic         pushout;
   logic [2:0]   doutix;
   logic [199:0] dout;
   logic         firstout;
   logic         finalout;

   int errs = 0;
   int checks = 0;

   logic [199:0] cap_d[2][8];
   logic         cap_f[2][8];
   logic         cap_l[2][8];
   exp_t         tbl[5];

   sha3_padder dut (
      .clk      (clk),
      .reset    (reset),
      .pushin   (pushin),
      .din      (din),
      .endin    (endin),
      .permrdy  (permrdy),
      .busy     (busy),
      .pushout  (pushout),
      .doutix   (doutix),
      .dout     (dout),
      .firstout (firstout),
      .finalout (finalout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [199:0] act,
                      input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send(input bq_t m);
      if (m.size() == 0) begin
         endin = 1'b1;
         @(negedge clk);
         endin = 1'b0;
      end else begin
         for (int i = 0; i < m.size(); i++) begin
            pushin = 1'b1;
            din    = m[i];
            endin  = (i == m.size() - 1);
            @(negedge clk);
         end
      end
      pushin = 1'b0;
      endin  = 1'b0;
      din    = 8'h00;
   endtask

   task automatic cap(input int bi, output int waited,
                      output bit ok);
      waited = 0;
      ok = 1'b1;
      while (!pushout && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      if (!pushout) begin
         ok = 1'b0;
      end else begin
         for (int ix = 0; ix < 8; ix++) begin
            if (!pushout || doutix != 3'(ix)) ok = 1'b0;
            cap_d[bi][ix] = dout;
            cap_f[bi][ix] = firstout;
            cap_l[bi][ix] = finalout;
            @(negedge clk);
         end
      end
   endtask

   task automatic cmp(input int sc, input int b);
      for (int k = 0; k < 5; k++) begin
         if (tbl[k].sc == sc && tbl[k].b == b) begin
            for (int ix = 0; ix < 8; ix++) begin
               chk($sformatf("sc%0d b%0d dout%0d", sc, b, ix),
                   cap_d[b][ix], tbl[k].d[ix]);
               chk($sformatf("sc%0d b%0d first%0d", sc, b, ix),
                   200'(cap_f[b][ix]),
                   200'((ix == 0) ? tbl[k].f : 1'b0));
               chk($sformatf("sc%0d b%0d final%0d", sc, b, ix),
                   200'(cap_l[b][ix]), 200'(tbl[k].l));
            end
         end
      end
   endtask

   task automatic quiet(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (pushout || busy) seen = 1'b1;
         @(negedge clk);
      end
      chk(nm, 200'(seen), 200'(0));
   endtask

   task automatic run_sc(input int sc, input bq_t m,
                         input int nb, input bit lat);
      int w;
      bit ok;
      send(m);
      chk($sformatf("sc%0d busy_after_end", sc),
          200'(busy), 200'(1));
      for (int b = 0; b < nb; b++) begin
         cap(b, w, ok);
         chk($sformatf("sc%0d b%0d burst_ok", sc, b),
             200'(ok), 200'(1));
         if (lat && b == 0) begin
            chk($sformatf("sc%0d latency", sc),
                200'(w), 200'(1));
         end
         cmp(sc, b);
      end
      quiet($sformatf("sc%0d no_extra", sc));
   endtask

   initial begin
      bq_t abc;
      bq_t empty;
      bq_t z135;
      bq_t f136;
      int  w;
      bit  ok;
      bit  bad;

      abc = '{8'h61, 8'h62, 8'h63, 8'h0a};
      empty = {};
      z135 = {};
      f136 = {};
      for (int i = 0; i < 135; i++) z135.push_back(8'h00);
      for (int i = 0; i < 136; i++) f136.push_back(8'hff);

      for (int k = 0; k < 5; k++) begin
         for (int ix = 0; ix < 8; ix++) tbl[k].d[ix] = '0;
      end
      tbl[0].sc = 0; tbl[0].b = 0;
      tbl[0].d[0] = 200'h060a636261;
      tbl[0].d[5] = 200'h80 << 80;
      tbl[0].f = 1'b1; tbl[0].l = 1'b1;
      tbl[1].sc = 1; tbl[1].b = 0;
      tbl[1].d[0] = 200'h06;
      tbl[1].d[5] = 200'h80 << 80;
      tbl[1].f = 1'b1; tbl[1].l = 1'b1;
      tbl[2].sc = 2; tbl[2].b = 0;
      tbl[2].d[5] = 200'h86 << 80;
      tbl[2].f = 1'b1; tbl[2].l = 1'b1;
      tbl[3].sc = 3; tbl[3].b = 0;
      for (int ix = 0; ix < 5; ix++) tbl[3].d[ix] = {200{1'b1}};
      tbl[3].d[5] = {112'd0, {88{1'b1}}};
      tbl[3].f = 1'b1; tbl[3].l = 1'b0;
      tbl[4].sc = 3; tbl[4].b = 1;
      tbl[4].d[0] = 200'h06;
      tbl[4].d[5] = 200'h80 << 80;
      tbl[4].f = 1'b0; tbl[4].l = 1'b1;

      reset = 1'b1;
      pushin = 1'b0;
      din = 8'h00;
      endin = 1'b0;
      permrdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst pushout", 200'(pushout), 200'(0));
      chk("rst doutix", 200'(doutix), 200'(0));
      chk("rst dout", dout, 200'(0));
      chk("rst firstout", 200'(firstout), 200'(0));
      chk("rst finalout", 200'(finalout), 200'(0));
      chk("rst busy", 200'(busy), 200'(0));
      reset = 1'b0;
      @(negedge clk);

      run_sc(0, abc, 1, 1'b1);
      run_sc(1, empty, 1, 1'b1);
      run_sc(2, z135, 1, 1'b1);
      run_sc(3, f136, 2, 1'b1);

      permrdy = 1'b0;
      send(abc);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (pushout || !busy) bad = 1'b1;
         @(negedge clk);
      end
      chk("hold stall", 200'(bad), 200'(0));
      permrdy = 1'b1;
      @(negedge clk);
      chk("hold first pushout", 200'(pushout), 200'(1));
      chk("hold first doutix", 200'(doutix), 200'(0));
      cap(0, w, ok);
      chk("hold burst_ok", 200'(ok), 200'(1));
      cmp(0, 0);
      quiet("hold no_extra");

      send(abc);
      w = 0;
      while (!(pushout && doutix == 3'd3) && w < 30) begin
         @(negedge clk);
         w++;
      end
      chk("rst mid reached beat3", 200'(pushout && doutix == 3'd3),
          200'(1));
      reset = 1'b1;
      @(negedge clk);
      chk("rst mid pushout", 200'(pushout), 200'(0));
      chk("rst mid busy", 200'(busy), 200'(0));
      reset = 1'b0;
      @(negedge clk);
      run_sc(0, abc, 1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/sha3_padder.md
# sha3_padder

SHA3-256 message padder and block packer that sits directly upstream of the `perm` Keccak permutation engine. It accepts a message one byte per cycle and accumulates bytes into a 1088-bit rate buffer. It applies SHA-3 domain padding (0x06 … 0x80) and emits each rate block as eight back-to-back 200-bit beats (`doutix` 0–7) that connect straight to `perm`'s `dix`/`din`/`pushin`. Beats 6–7 and bits 1199:1088 of beat 5 are always zero (capacity).

## Interface
- `RATE_BYTES`, 136, rate in bytes; must be ≤150 so the rate fits in beats 0–5.
- `DSBYTE`, 8'h06, domain-separation byte.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named `clk` and `reset`.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `pushin`  in  1  `din` is a valid message byte this cycle
- `din`  in  8  message byte
- `endin`  in  1  message ends here; see Operation for the rules with and without `pushin`
- `permrdy`  in  1  `perm` can accept a new 8-beat burst
- `busy`  out  1  padder cannot accept bytes; bytes pushed while high are dropped
- `pushout`  out  1  beat valid
- `doutix`  out  3  beat index
- `dout`  out  200  beat data
- `firstout`  out  1  high with beat 0 of a message's first block
- `finalout`  out  1  high on all 8 beats of a message's last block

## Operation
- **Byte mapping:** message byte k of the current block goes to buffer bits 8k+7:8k. Beat i carries block bits 200i+199:200i.
- **States:** FILL, READY, EMIT, PADBLK.
- **FILL:** each `pushin` writes `din` at byte index `cnt`, then `cnt++`.
  - `endin` with `pushin`: the byte is written first, then the block is padded.
  - `endin` alone: the block is padded at the current `cnt`. If `cnt=0`, this is the empty message or an exact-multiple tail.
- **Padding at index p:**
  - byte p ^= `DSBYTE`.
  - byte RATE_BYTES-1 ^= 0x80.
  - If p=RATE_BYTES-1, that byte becomes 0x86.
  - Unused bytes are zero.
- **Block fills to RATE_BYTES without `endin`:** go to READY, non-final.
- **Byte RATE_BYTES-1 pushed with `endin`:** the block goes to READY, non-final, and `padpend` is set. After its burst the FSM goes to PADBLK.
- **PADBLK:** builds a pad-only block (byte 0 = `DSBYTE`, byte 135 = 0x80, rest zero), final, then goes to READY.
- **READY:** waits for `permrdy=1`, then goes to EMIT.
- **EMIT:** 8 consecutive cycles, `doutix` 0..7, `pushout=1`. After beat 7:
  - buffer cleared and `cnt=0`;
  - go to PADBLK if `padpend`, else FILL.
- **`firstout`:** a `msgfirst` flag is set at reset and after every final burst, and cleared after any burst. `firstout` = `msgfirst` on beat 0.
- **`finalout`:** set for every beat of a padded block.
- **`busy`:** high in READY, EMIT and PADBLK, and in FILL on the cycle after the block completes.
- **Buffer:** a single buffer; no overlap of fill and emit.

## Timing
- **Reset values:** `pushout=0`, `doutix=0`, `dout=0`, `firstout=0`, `finalout=0`, `busy=0`, state FILL, `cnt=0`, `msgfirst=1`, `padpend=0`.
- **Outputs:** all registered.
- **Completion to first beat:** the last byte or `endin` is sampled at edge t, giving READY at t+1.
  - If `permrdy` is sampled 1 at edge t+1, beats 0..7 appear in cycles t+2..t+9.
  - `permrdy` is not rechecked mid-burst.
- **Bytes:** `busy` goes high the cycle after completion. Upstream may push one byte per cycle whenever `busy=0`.
- **PADBLK to READY:** 1 cycle.
- **Simultaneous events:** `endin` without `pushin` while `busy` is ignored.
- **Reset mid-burst:** `pushout=0` from the next cycle. The partial burst is abandoned; `perm` sees ≤7 beats and must also be reset.

## Structure
- Package `sha3_pkg` holds:
  - `RATE_BYTES`=136, `BEATS`=8, `BEAT_W`=200, `STATE_W`=1600;
  - `DSBYTE_SHA3`=8'h06, `PAD_LAST`=8'h80;
  - state enum `pad_state_t`.
- No sub-module; the buffer, byte-write logic and FSM live in one module.

## Test plan
- Bytes 61 62 63 0a, `endin` on 0a, `permrdy=1`:
  - beat0 = 200'h60a636261, beat5 = 200'h80<<80, other beats 0;
  - `firstout` on beat0, `finalout` on all 8 beats.
- Empty message (`endin` alone):
  - beat0 = 200'h06, beat5 = 200'h80<<80.
- 135 bytes 0x00, `endin` on the last byte:
  - beat5 = 200'h86<<80, single burst.
- 136 bytes 0xFF, `endin` on the last byte:
  - burst 1: beats 0–4 all-ones, beat5 = 88'hFF…FF (11 bytes), `finalout=0`, `firstout=1`;
  - burst 2: beat0 = 200'h06, beat5 = 200'h80<<80, `firstout=0`, `finalout=1`.
- Hold `permrdy=0` for 10 cycles after completion:
  - `pushout=0` and `busy=1` throughout;
  - raise `permrdy`: beat0 appears the next cycle, 8 contiguous beats.
- Assert `reset` during beat 3:
  - next cycle `pushout=0` and `busy=0`;
  - a following "abc\n" message reproduces scenario 1 exactly.
